// File: rtl/alu_arbiter_pkg.sv
// Shared constants and ALU op encodings for the two-port ALU arbiter.
package alu_arbiter_pkg;

    localparam int unsigned DataW = 32;
    localparam int unsigned OpW   = 3;
    localparam int unsigned CntW  = 16;

    typedef enum logic [OpW-1:0] {
        OpAdd = 3'b000,
        OpSub = 3'b001,
        OpOr  = 3'b010,
        OpEq  = 3'b011
    } alu_op_e;

endpackage

// File: rtl/alu_arbiter_alu_core.sv
// Combinational ALU shared by both request ports; undefined ops yield zero.
module alu_core
    import alu_arbiter_pkg::*;
(
    input  logic [OpW-1:0]   op_i,
    input  logic [DataW-1:0] in1_i,
    input  logic [DataW-1:0] in2_i,
    output logic [DataW-1:0] out_o
);

    always_comb begin
        out_o = '0;
        case (op_i)
            OpAdd:   out_o = in1_i + in2_i;
            OpSub:   out_o = in1_i - in2_i;
            OpOr:    out_o = in1_i | in2_i;
            OpEq:    out_o = {{(DataW-1){1'b0}}, (in1_i == in2_i)};
            default: out_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of one ALU with a single registered result slot.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter bit Fair = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid0_i,
    input  logic             req_valid1_i,
    output logic             req_ready0_o,
    output logic             req_ready1_o,
    input  logic [OpW-1:0]   req_op0_i,
    input  logic [OpW-1:0]   req_op1_i,
    input  logic [DataW-1:0] req_a0_i,
    input  logic [DataW-1:0] req_b0_i,
    input  logic [DataW-1:0] req_a1_i,
    input  logic [DataW-1:0] req_b1_i,
    output logic             rsp_valid0_o,
    output logic             rsp_valid1_o,
    input  logic             rsp_ready0_i,
    input  logic             rsp_ready1_i,
    output logic [DataW-1:0] rsp_data_o,
    output logic [CntW-1:0]  xact_cnt_o
);

    logic             out_valid_q, out_valid_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic [DataW-1:0] result_q, result_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             drain;
    logic             slot_free;
    logic             grant0, grant1;
    logic             accept;
    logic [OpW-1:0]   alu_op;
    logic [DataW-1:0] alu_a, alu_b, alu_out;

    // Only the owner's rsp_ready can drain the slot.
    assign drain     = out_valid_q && (owner_q ? rsp_ready1_i : rsp_ready0_i);
    assign slot_free = !out_valid_q || drain;

    // Port 1 wins a tie only when fair and port 0 was granted last.
    assign grant1 = req_valid1_i && (!req_valid0_i || (Fair && !last_grant_q));
    assign grant0 = req_valid0_i && !grant1;

    assign req_ready0_o = rst_ni && grant0 && slot_free;
    assign req_ready1_o = rst_ni && grant1 && slot_free;
    assign accept       = req_ready0_o || req_ready1_o;

    assign alu_op = grant1 ? req_op1_i : req_op0_i;
    assign alu_a  = grant1 ? req_a1_i  : req_a0_i;
    assign alu_b  = grant1 ? req_b1_i  : req_b0_i;

    alu_core u_alu_core (
        .op_i  (alu_op),
        .in1_i (alu_a),
        .in2_i (alu_b),
        .out_o (alu_out)
    );

    always_comb begin
        out_valid_d  = out_valid_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        result_d     = result_q;
        cnt_d        = cnt_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            owner_d      = grant1;
            last_grant_d = grant1;
            result_d     = alu_out;
            cnt_d        = cnt_q + 16'd1;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q  <= 1'b0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            result_q     <= '0;
            cnt_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            result_q     <= result_d;
            cnt_q        <= cnt_d;
        end
    end

    assign rsp_valid0_o = out_valid_q && !owner_q;
    assign rsp_valid1_o = out_valid_q && owner_q;
    assign rsp_data_o   = result_q;
    assign xact_cnt_o   = cnt_q;

endmodule
